// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 once at start, then C/D rotation and PC-2 per handshake.
// Optional weak-key flag enabled by defining DES_WEAK_KEY_DETECT_EN.
module des_key_schedule #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        start,
    output logic        busy,
    output logic [47:0] round_key,
    output logic        round_key_valid,
    input  logic        round_key_ready,
    output logic [3:0]  round_idx,
    output logic        done,
    output logic        weak_key
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // DES numbers bits from 1 at the MSB, so DES bit n sits at vector index width-n.
    function automatic logic [55:0] pc1_f(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - PC1[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2[i])];
        end
        return r;
    endfunction

    function automatic logic [1:0] shamt_f(input logic [3:0] rnd);
        logic [1:0] s;
        case (rnd)
            4'd0, 4'd1, 4'd8, 4'd15: s = 2'd1;
            default:                 s = 2'd2;
        endcase
        return s;
    endfunction

    function automatic logic [27:0] rol_f(input logic [27:0] x,
                                          input logic [1:0]  n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror_f(input logic [27:0] x,
                                          input logic [1:0]  n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [47:0] rk_q, rk_d;
    logic [3:0]  idx_q, idx_d;
    logic        dir_q, dir_d;
    logic        key_upd;

    logic [55:0] cd0;
    logic [27:0] c0;
    logic [27:0] d0;
    logic [1:0]  enc_sh;
    logic [1:0]  dec_sh;
    logic        unused_parity;

    assign cd0    = pc1_f(key_in);
    assign c0     = cd0[55:28];
    assign d0     = cd0[27:0];
    assign enc_sh = shamt_f(idx_q + 4'd1);
    assign dec_sh = shamt_f(LAST - idx_q);

    assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        key_upd = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    dir_d   = decrypt;
                    idx_d   = 4'd0;
                    key_upd = 1'b1;
                    // Decrypt starts at K16, whose C16/D16 equal C0/D0.
                    c_d     = decrypt ? c0 : rol_f(c0, 2'd1);
                    d_d     = decrypt ? d0 : rol_f(d0, 2'd1);
                end
            end
            RUN: begin
                if (round_key_ready) begin
                    if (idx_q == LAST) begin
                        state_d = DONE;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        key_upd = 1'b1;
                        c_d     = dir_q ? ror_f(c_q, dec_sh) : rol_f(c_q, enc_sh);
                        d_d     = dir_q ? ror_f(d_q, dec_sh) : rol_f(d_q, enc_sh);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The key register is loaded from the next C/D so it is valid one cycle after start.
    assign rk_d = key_upd ? pc2_f({c_d, d_d}) : rk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            rk_q    <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            rk_q    <= rk_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
        end
    end

    assign busy            = (state_q == RUN);
    assign round_key_valid = (state_q == RUN);
    assign done            = (state_q == DONE);
    assign round_key       = rk_q;
    assign round_idx       = idx_q;

`ifdef DES_WEAK_KEY_DETECT_EN
    logic weak_q, weak_d;

    always_comb begin
        weak_d = weak_q;
        if (state_q == IDLE && start) begin
            weak_d = ((c0 == '0) || (c0 == '1)) && ((d0 == '0) || (d0 == '1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weak_q <= 1'b0;
        end else begin
            weak_q <= weak_d;
        end
    end

    assign weak_key = weak_q;
`else
    assign weak_key = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: expected keys from a reference model
// and the published K1/K2/K16 vectors, compared at each handshake.
module tb_des_key_schedule;

    logic        clk;
    logic        rst_n;
    logic [63:0] key_in;
    logic        decrypt;
    logic        start;
    logic        busy;
    logic [47:0] round_key;
    logic        round_key_valid;
    logic        round_key_ready;
    logic [3:0]  round_idx;
    logic        done;
    logic        weak_key;

    des_key_schedule dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key_in          (key_in),
        .decrypt         (decrypt),
        .start           (start),
        .busy            (busy),
        .round_key       (round_key),
        .round_key_valid (round_key_valid),
        .round_key_ready (round_key_ready),
        .round_idx       (round_idx),
        .done            (done),
        .weak_key        (weak_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KEY_W = 64'h0101010101010101;
    localparam logic [47:0] K1    = 48'h1B02EFFC7072;
    localparam logic [47:0] K2    = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16   = 48'hCB3D8B0E17F5;

`ifdef DES_WEAK_KEY_DETECT_EN
    localparam logic WEAK_EXP = 1'b1;
`else
    localparam logic WEAK_EXP = 1'b0;
`endif

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct {
        logic [47:0] key;
        logic [3:0]  idx;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Kn computed from C0/D0 by the cumulative left rotation after n rounds.
    function automatic logic [47:0] ref_key(input logic [63:0] k, input int n);
        bit          cd0 [57];
        bit          cdn [57];
        logic [47:0] res;
        int          cum;
        int          j;
        for (j = 1; j <= 56; j++) cd0[j] = k[64 - PC1_T[j - 1]];
        cum = 0;
        for (j = 0; j < n; j++) cum += SHIFT_T[j];
        for (j = 1; j <= 28; j++) begin
            cdn[j]      = cd0[((j - 1 + cum) % 28) + 1];
            cdn[28 + j] = cd0[28 + ((j - 1 + cum) % 28) + 1];
        end
        res = '0;
        for (j = 1; j <= 48; j++) res[48 - j] = cdn[PC2_T[j - 1]];
        return res;
    endfunction

    task automatic push_exp(input logic [63:0] mk, input logic dec);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.idx = 4'(i);
            e.key = ref_key(mk, dec ? 16 - i : i + 1);
            if (mk == KEY_A) begin
                if (!dec && i == 0)  e.key = K1;
                if (!dec && i == 1)  e.key = K2;
                if (!dec && i == 15) e.key = K16;
                if (dec && i == 0)   e.key = K16;
                if (dec && i == 14)  e.key = K2;
                if (dec && i == 15)  e.key = K1;
            end
            sb.push_back(e);
        end
    endtask

    task automatic run_seq(input string nm, input logic [63:0] drv_key,
                           input logic [63:0] mdl_key, input logic dec,
                           input bit bp, input bit extra_start,
                           input logic exp_weak);
        int  got;
        int  cyc;
        bit  rdy;
        bit  pulsed;
        sb.delete();
        push_exp(mdl_key, dec);
        @(negedge clk);
        key_in          = drv_key;
        decrypt         = dec;
        start           = 1'b1;
        round_key_ready = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        key_in  = ~drv_key;
        decrypt = ~dec;
        check({nm, ".busy_t1"}, 64'(busy), 64'd1);
        check({nm, ".weak_t1"}, 64'(weak_key), 64'(exp_weak));
        got    = 0;
        cyc    = 0;
        pulsed = 0;
        while (got < 16 && cyc < 200) begin
            start = 1'b0;
            check({nm, ".valid"}, 64'(round_key_valid), 64'd1);
            check({nm, ".key"}, 64'(round_key), 64'(sb[0].key));
            check({nm, ".idx"}, 64'(round_idx), 64'(sb[0].idx));
            rdy = bp ? (cyc % 3 == 0) : 1'b1;
            round_key_ready = rdy;
            if (extra_start && got == 5 && !pulsed) begin
                start   = 1'b1;
                key_in  = KEY_B;
                decrypt = 1'b1;
                pulsed  = 1;
            end
            if (rdy) begin
                void'(sb.pop_front());
                got++;
                if (extra_start && got == 16) start = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        round_key_ready = 1'b0;
        check({nm, ".transfers"}, 64'(got), 64'd16);
        check({nm, ".cycles"}, 64'(cyc), bp ? 64'd46 : 64'd16);
        check({nm, ".done"}, 64'(done), 64'd1);
        check({nm, ".valid_end"}, 64'(round_key_valid), 64'd0);
        check({nm, ".busy_end"}, 64'(busy), 64'd0);
        check({nm, ".idx_end"}, 64'(round_idx), 64'd0);
        check({nm, ".weak_hold"}, 64'(weak_key), 64'(exp_weak));
        if (extra_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({nm, ".done_pulse"}, 64'(done), 64'd0);
        check({nm, ".idle_valid"}, 64'(round_key_valid), 64'd0);
        check({nm, ".idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int wait_cyc;
        rst_n           = 1'b0;
        key_in          = '0;
        decrypt         = 1'b0;
        start           = 1'b0;
        round_key_ready = 1'b0;
        #12;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.valid", 64'(round_key_valid), 64'd0);
        check("rst.idx", 64'(round_idx), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.weak", 64'(weak_key), 64'd0);
        check("rst.key", 64'(round_key), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_seq("enc", KEY_A, KEY_A, 1'b0, 0, 0, 1'b0);
        run_seq("dec", KEY_A, KEY_A, 1'b1, 0, 0, 1'b0);
        run_seq("bp", KEY_A, KEY_A, 1'b0, 1, 0, 1'b0);
        run_seq("restart", KEY_A, KEY_A, 1'b0, 0, 1, 1'b0);
        run_seq("parity", KEY_A ^ 64'h0101010101010101, KEY_A, 1'b0, 0, 0, 1'b0);
        run_seq("keyb_dec", KEY_B, KEY_B, 1'b1, 1, 0, 1'b0);

        @(negedge clk);
        key_in          = KEY_A;
        decrypt         = 1'b0;
        start           = 1'b1;
        round_key_ready = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_cyc = 0;
        while (round_idx != 4'd7 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("rst_mid.reach7", 64'(round_idx), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.valid", 64'(round_key_valid), 64'd0);
        check("rst_mid.busy", 64'(busy), 64'd0);
        check("rst_mid.done", 64'(done), 64'd0);
        check("rst_mid.idx", 64'(round_idx), 64'd0);
        round_key_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_seq("after_rst", KEY_A, KEY_A, 1'b0, 0, 0, 1'b0);

        run_seq("weak", KEY_W, KEY_W, 1'b0, 0, 0, WEAK_EXP);
        run_seq("nonweak", KEY_A, KEY_A, 1'b0, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Iterative DES key-schedule generator; the producer of the 48-bit round keys that des_func consumes.
- Accepts a 64-bit key with parity bits and emits K1..K16 in order (encrypt) or K16..K1 (decrypt), one key per valid/ready handshake.
- Sits between the key register file and the round datapath of the DES/3DES core.

Parameters:
- NUM_ROUNDS, 16, rounds emitted per key; fixed at 16 for DES, exposed only for bench shortening.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_in  input  64  DES key, bit 63 = DES bit 1; parity bits (DES bits 8,16,...,64) ignored.
- decrypt  input  1  sampled with start; 1 = emit keys in reverse order.
- start  input  1  one-cycle request; honoured only in IDLE.
- busy  output  1  high from accepted start until the final handshake.
- round_key  output  48  PC-2 output, bit 47 = DES bit 1.
- round_key_valid  output  1  round_key holds a valid key.
- round_key_ready  input  1  consumer accepts round_key.
- round_idx  output  4  index of the presented key, 0..15 (0 = K1 for encrypt, 0 = K16 for decrypt).
- done  output  1  one-cycle pulse after the last key is accepted.
- weak_key  output  1  weak-key flag (see Optional Feature).

Behaviour:
- Reset values: state IDLE, busy=0, round_key_valid=0, round_idx=0, done=0, weak_key=0. Internal C/D and round_key registers are 0.
- States:
  - IDLE: start=1 → RUN.
  - RUN: handshake on round NUM_ROUNDS-1 → DONE.
  - DONE: one cycle, then IDLE.
- Start (cycle T), in IDLE with start=1:
  - Apply PC-1 to key_in to get C0/D0 (28 bits each).
  - Encrypt: load C/D rotated left by 1. Decrypt: load C0/D0 unrotated.
  - Latch decrypt into dir.
  - busy=1 from T+1.
- First key: round_key_valid=1 at T+1, round_idx=0. round_key = PC-2(C,D) is registered, with stable hold.
- Handshake: a transfer occurs when round_key_valid && round_key_ready on a rising edge.
  - On a transfer with round_idx < NUM_ROUNDS-1: round_idx increments and C/D rotate.
  - Encrypt rotates left by shift[round_idx+1]. Decrypt rotates right by shift[NUM_ROUNDS-1-round_idx].
  - shift table = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - round_key_valid stays 1, so back-to-back transfers give one key per cycle.
- Stall: while ready=0, round_key, round_idx and C/D hold unchanged.
- Last transfer (round_idx = NUM_ROUNDS-1): round_key_valid=0 and busy=0 next cycle, done=1 for exactly that cycle (DONE state), round_idx returns to 0.
- start while busy or in DONE: ignored, no effect on the sequence.
- start and the final handshake on the same edge: start ignored. A new start is honoured from the cycle after done.
- key_in and decrypt are sampled only at an accepted start; later changes have no effect.
- rst_n low at any time: immediate return to reset values, and any in-flight sequence is abandoned.
- Total left rotation over 16 encrypt rounds = 28, so C/D return to C0/D0.

Optional Feature:
- Macro DES_WEAK_KEY_DETECT_EN.
- Defined:
  - At an accepted start, weak_key is registered to 1 iff PC-1 C0 is all-0 or all-1 AND D0 is all-0 or all-1 (the four DES weak keys).
  - weak_key holds until the next accepted start or reset; key generation proceeds normally.
- Undefined: weak_key is tied 0 and no detection logic is present.

Test Plan:
- Encrypt, key_in=64'h133457799BBCDFF1, ready held 1: valid at T+1; K1=48'h1B02EFFC7072 (idx 0), K2=48'h79AED9DBC9E5 (idx 1), K16=48'hCB3D8B0E17F5 (idx 15); done pulses one cycle after K16; 16 consecutive valid cycles.
- Decrypt with the same key: idx 0 = 48'hCB3D8B0E17F5, idx 14 = 48'h79AED9DBC9E5, idx 15 = 48'h1B02EFFC7072.
- Backpressure: ready toggles 1,0,0,1,... → each key held stable while ready=0; sequence and values identical to the first scenario; done only after 16 transfers.
- start re-pulsed mid-sequence with a different key_in and decrypt=1 → ignored, remaining keys still from the first key in encrypt order. Parity bits flipped in key_in → identical keys.
- rst_n asserted at idx 7 → valid/busy/done/idx go 0 asynchronously. A new start after release restarts at K1.
- With DES_WEAK_KEY_DETECT_EN defined: key 64'h0101010101010101 → weak_key=1 at T+1; key 64'h133457799BBCDFF1 → weak_key=0. Without the macro, weak_key is always 0.
